// File: rtl/payload_crc_sequencer.sv
// Receive-side sequencer for an Ethernet-style byte stream. It tracks the frame fields,
// feeds dst..payload to an external CRC engine, checks the FCS and reports per-frame status.
module payload_crc_sequencer #(
    parameter int unsigned MIN_PAYLOAD = 46,
    parameter int unsigned MAX_PAYLOAD = 1500,
    parameter int unsigned CNT_W       = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [7:0]       data,
    input  logic             control,
    output logic             crc_init,
    output logic             crc_enable,
    output logic [7:0]       crc_data,
    input  logic [31:0]      crc_value,
    output logic             busy,
    output logic             frame_done,
    output logic             frame_ok,
    output logic             length_error,
    output logic             crc_error,
    output logic             frame_abort,
    output logic [CNT_W-1:0] valid_packet_counter
);

    localparam logic [15:0] MinLen = 16'(MIN_PAYLOAD);
    localparam logic [15:0] MaxLen = 16'(MAX_PAYLOAD);

    typedef enum logic [3:0] {
        StIdle,
        StPreamble,
        StSfd,
        StDst,
        StSrc,
        StTypeLen,
        StPayload,
        StFcs,
        StCheck
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        len_q, len_d;
    logic [31:0]        fcs_q, fcs_d;
    logic               crc_init_q, crc_init_d;
    logic               crc_enable_q, crc_enable_d;
    logic [7:0]         crc_data_q, crc_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ok_q, ok_d;
    logic               len_err_q, len_err_d;
    logic               crc_err_q, crc_err_d;
    logic               abort_q, abort_d;
    logic [CNT_W-1:0]   pkt_cnt_q, pkt_cnt_d;

    logic               in_frame;
    logic [15:0]        len_full;

    // Frame body states: dropping control here aborts the frame.
    assign in_frame = (state_q == StDst) || (state_q == StSrc) || (state_q == StTypeLen) ||
                      (state_q == StPayload) || (state_q == StFcs);
    // Big-endian length as seen while accepting the second type/length byte.
    assign len_full = {len_q[15:8], data};

    // Next-state, field counters, CRC feed and registered status values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        fcs_d        = fcs_q;
        crc_init_d   = 1'b0;
        crc_enable_d = 1'b0;
        crc_data_d   = crc_data_q;
        done_d       = 1'b0;
        ok_d         = 1'b0;
        len_err_d    = 1'b0;
        crc_err_d    = 1'b0;
        abort_d      = 1'b0;
        pkt_cnt_d    = pkt_cnt_q;

        if (in_frame && !control) begin
            state_d = StIdle;
            cnt_d   = '0;
            done_d  = 1'b1;
            abort_d = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (control && data == 8'h55) begin
                        state_d = StPreamble;
                        cnt_d   = 16'd1;
                    end
                end
                StPreamble: begin
                    if (control) begin
                        if (data == 8'h55) begin
                            if (cnt_q == 16'd6) begin
                                state_d = StSfd;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 16'd1;
                            end
                        end else begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end
                    end
                end
                StSfd: begin
                    if (control) begin
                        cnt_d = '0;
                        if (data == 8'hD5) begin
                            state_d    = StDst;
                            crc_init_d = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                StDst, StSrc: begin
                    crc_enable_d = 1'b1;
                    crc_data_d   = data;
                    if (cnt_q == 16'd5) begin
                        state_d = (state_q == StDst) ? StSrc : StTypeLen;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StTypeLen: begin
                    crc_enable_d = 1'b1;
                    crc_data_d   = data;
                    if (cnt_q == 16'd0) begin
                        len_d = {data, 8'h00};
                        cnt_d = 16'd1;
                    end else begin
                        len_d = len_full;
                        cnt_d = '0;
                        if (len_full < MinLen || len_full > MaxLen) begin
                            state_d   = StIdle;
                            done_d    = 1'b1;
                            len_err_d = 1'b1;
                        end else begin
                            state_d = StPayload;
                        end
                    end
                end
                StPayload: begin
                    crc_enable_d = 1'b1;
                    crc_data_d   = data;
                    if (cnt_q == len_q - 16'd1) begin
                        state_d = StFcs;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StFcs: begin
                    // Little-endian: after four shifts the first byte sits in bits 7:0.
                    fcs_d = {data, fcs_q[31:8]};
                    if (cnt_q == 16'd3) begin
                        state_d = StCheck;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StCheck: begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    if (fcs_q == crc_value) begin
                        ok_d      = 1'b1;
                        pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                    end else begin
                        crc_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end

        busy_d = (state_d != StIdle);
    end

    // State and registered outputs; reset clears everything asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            len_q        <= '0;
            fcs_q        <= '0;
            crc_init_q   <= 1'b0;
            crc_enable_q <= 1'b0;
            crc_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ok_q         <= 1'b0;
            len_err_q    <= 1'b0;
            crc_err_q    <= 1'b0;
            abort_q      <= 1'b0;
            pkt_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            fcs_q        <= fcs_d;
            crc_init_q   <= crc_init_d;
            crc_enable_q <= crc_enable_d;
            crc_data_q   <= crc_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ok_q         <= ok_d;
            len_err_q    <= len_err_d;
            crc_err_q    <= crc_err_d;
            abort_q      <= abort_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

    assign crc_init             = crc_init_q;
    assign crc_enable           = crc_enable_q;
    assign crc_data             = crc_data_q;
    assign busy                 = busy_q;
    assign frame_done           = done_q;
    assign frame_ok             = ok_q;
    assign length_error         = len_err_q;
    assign crc_error            = crc_err_q;
    assign frame_abort          = abort_q;
    assign valid_packet_counter = pkt_cnt_q;

endmodule

// File: tb/tb_payload_crc_sequencer.sv
// Bench for payload_crc_sequencer: a directed table, hand sequences for back-to-back frames
// and reset, and random frames checked against a frame-level outcome model.
module tb_payload_crc_sequencer;

    localparam int KNone  = 0;
    localparam int KOk    = 1;
    localparam int KLen   = 2;
    localparam int KCrc   = 3;
    localparam int KAbort = 4;
    localparam int MinPay = 46;
    localparam int MaxPay = 1500;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  data;
    logic        control;
    logic        crc_init;
    logic        crc_enable;
    logic [7:0]  crc_data;
    logic [31:0] crc_value;
    logic        busy;
    logic        frame_done;
    logic        frame_ok;
    logic        length_error;
    logic        crc_error;
    logic        frame_abort;
    logic [3:0]  valid_packet_counter;

    payload_crc_sequencer #(
        .MIN_PAYLOAD(MinPay),
        .MAX_PAYLOAD(MaxPay),
        .CNT_W(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .data(data),
        .control(control),
        .crc_init(crc_init),
        .crc_enable(crc_enable),
        .crc_data(crc_data),
        .crc_value(crc_value),
        .busy(busy),
        .frame_done(frame_done),
        .frame_ok(frame_ok),
        .length_error(length_error),
        .crc_error(crc_error),
        .frame_abort(frame_abort),
        .valid_packet_counter(valid_packet_counter)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int frame_no = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (frame %0d): got %0h, expected %0h", name, frame_no, act, exp);
        end
    endtask

    // Simple MSB-first CRC-32 engine standing in for the real one.
    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[31] ^ b[i];
            c  = {c[30:0], 1'b0};
            if (fb) c = c ^ 32'h04C1_1DB7;
        end
        return c;
    endfunction

    logic [31:0] eng;
    always @(posedge clock or posedge reset) begin
        if (reset)           eng <= 32'hFFFF_FFFF;
        else if (crc_init)   eng <= 32'hFFFF_FFFF;
        else if (crc_enable) eng <= crc_step(eng, crc_data);
    end
    assign crc_value = eng;

    // Observed activity per frame.
    logic [7:0] feed_seen[$];
    logic [3:0] done_seen[$];
    int         init_cnt;
    int         done_cyc;

    always @(negedge clock) begin
        logic [3:0] fl;
        logic       bad;
        fl = {frame_ok, length_error, crc_error, frame_abort};
        if (crc_enable) feed_seen.push_back(crc_data);
        if (crc_init) init_cnt++;
        if (frame_done) begin
            done_seen.push_back(fl);
            done_cyc = cyc;
        end
        bad = frame_done ? ($countones(fl) != 1) : (fl != 4'b0);
        chk("flags_exclusive", 64'(bad), 64'd0);
    end

    // Reference frame: body after SFD and the bytes that should reach the CRC engine.
    logic [7:0] frm_q[$];
    logic [7:0] ref_feed_q[$];
    logic [3:0] exp_cnt;

    function automatic logic [31:0] crc_of_ref();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (ref_feed_q[i]) c = crc_step(c, ref_feed_q[i]);
        return c;
    endfunction

    task automatic build_frame(input logic [15:0] len_field, input int npay,
                               input logic [7:0] fcs_x);
        logic [31:0] c;
        ref_feed_q.delete();
        for (int i = 0; i < 12; i++) ref_feed_q.push_back(8'($urandom));
        ref_feed_q.push_back(len_field[15:8]);
        ref_feed_q.push_back(len_field[7:0]);
        for (int i = 0; i < npay; i++) ref_feed_q.push_back(8'($urandom));
        c = crc_of_ref();
        frm_q = ref_feed_q;
        frm_q.push_back(c[7:0] ^ fcs_x);
        frm_q.push_back(c[15:8]);
        frm_q.push_back(c[23:16]);
        frm_q.push_back(c[31:24]);
    endtask

    // Frame-level outcome from the receive rules.
    function automatic int classify(input int npre, input logic [7:0] sfd, input int len,
                                    input logic [7:0] fcs_x, input int abort_at);
        if (npre != 7 || sfd != 8'hD5) return KNone;
        if (abort_at >= 0 && abort_at < 14) return KAbort;
        if (len < MinPay || len > MaxPay) return KLen;
        if (abort_at >= 0 && abort_at < 14 + len + 4) return KAbort;
        return (fcs_x != 8'h00) ? KCrc : KOk;
    endfunction

    task automatic drive_byte(input logic [7:0] b, input logic c);
        data    = b;
        control = c;
        @(negedge clock);
        #1;
    endtask

    task automatic run_frame(input int npre, input logic [7:0] sfd, input logic [15:0] len_field,
                             input int npay, input logic [7:0] fcs_x, input int abort_at,
                             input int kind, input bit b2b);
        int         n_feed;
        int         exp_lat;
        int         bad;
        int         last_edge;
        logic [3:0] exp_fl;
        frame_no++;
        build_frame(len_field, npay, fcs_x);
        feed_seen.delete();
        done_seen.delete();
        init_cnt = 0;
        done_cyc = -100;
        for (int i = 0; i < npre; i++) drive_byte(8'h55, 1'b1);
        drive_byte(sfd, 1'b1);
        last_edge = cyc;
        if (npre == 7 && sfd == 8'hD5) begin
            for (int i = 0; i < frm_q.size(); i++) begin
                if (i == abort_at) begin
                    drive_byte(frm_q[i], 1'b0);
                    last_edge = cyc;
                    break;
                end
                drive_byte(frm_q[i], 1'b1);
                last_edge = cyc;
                if (i == 13 && (int'(len_field) < MinPay || int'(len_field) > MaxPay)) break;
            end
        end
        if (b2b) begin
            drive_byte(8'h55, 1'b1);  // lands in the check cycle and must be ignored
        end else begin
            repeat (5) drive_byte(8'h00, 1'b0);
        end

        case (kind)
            KOk:     begin exp_fl = 4'b1000; exp_lat = 2; n_feed = ref_feed_q.size(); end
            KCrc:    begin exp_fl = 4'b0010; exp_lat = 2; n_feed = ref_feed_q.size(); end
            KLen:    begin exp_fl = 4'b0100; exp_lat = 1; n_feed = 14; end
            KAbort:  begin
                exp_fl  = 4'b0001;
                exp_lat = 1;
                n_feed  = (abort_at < ref_feed_q.size()) ? abort_at : ref_feed_q.size();
            end
            default: begin exp_fl = 4'b0000; exp_lat = 0; n_feed = 0; end
        endcase
        if (kind == KOk) exp_cnt = exp_cnt + 4'd1;

        chk("done_count", 64'(done_seen.size()), (kind == KNone) ? 64'd0 : 64'd1);
        if (kind != KNone && done_seen.size() > 0) begin
            chk("status_flags", 64'(done_seen[0]), 64'(exp_fl));
            // Edge at which a synchronous consumer first samples frame_done high.
            chk("done_latency", 64'(done_cyc + 1 - last_edge), 64'(exp_lat));
        end
        chk("crc_init_count", 64'(init_cnt), (kind == KNone) ? 64'd0 : 64'd1);
        chk("feed_count", 64'(feed_seen.size()), 64'(n_feed));
        bad = 0;
        for (int i = 0; i < n_feed && i < feed_seen.size(); i++)
            if (feed_seen[i] !== ref_feed_q[i]) bad++;
        chk("feed_bytes", 64'(bad), 64'd0);
        chk("packet_counter", 64'(valid_packet_counter), 64'(exp_cnt));
        chk("busy_after", 64'(busy), 64'd0);
    endtask

    typedef struct {
        int          npre;
        logic [7:0]  sfd;
        logic [15:0] len;
        int          npay;
        logic [7:0]  fcs_x;
        int          abort_at;
        int          kind;
    } vec_t;

    vec_t tbl[12];

    logic [19:0] outs;
    assign outs = {crc_init, crc_enable, crc_data, busy, frame_done, frame_ok, length_error,
                   crc_error, frame_abort, valid_packet_counter};

    initial begin
        tbl[0]  = '{7, 8'hD5, 16'd46,    46,   8'h00, -1,          KOk};
        tbl[1]  = '{7, 8'hD5, 16'd46,    46,   8'h01, -1,          KCrc};
        tbl[2]  = '{7, 8'hD5, 16'h0600,  0,    8'h00, -1,          KLen};
        tbl[3]  = '{7, 8'hD5, 16'd45,    0,    8'h00, -1,          KLen};
        tbl[4]  = '{6, 8'hD5, 16'd46,    46,   8'h00, -1,          KNone};
        tbl[5]  = '{7, 8'hD4, 16'd46,    46,   8'h00, -1,          KNone};
        tbl[6]  = '{7, 8'hD5, 16'd46,    46,   8'h00, 14 + 10,     KAbort};
        tbl[7]  = '{7, 8'hD5, 16'd46,    46,   8'h00, -1,          KOk};
        tbl[8]  = '{7, 8'hD5, 16'd1500,  1500, 8'h00, -1,          KOk};
        tbl[9]  = '{7, 8'hD5, 16'd1501,  0,    8'h00, -1,          KLen};
        tbl[10] = '{7, 8'hD5, 16'd47,    47,   8'h00, 3,           KAbort};
        tbl[11] = '{7, 8'hD5, 16'd50,    50,   8'h00, 14 + 50 + 2, KAbort};

        exp_cnt  = 4'd0;
        init_cnt = 0;
        done_cyc = -100;
        reset    = 1'b1;
        control  = 1'b0;
        data     = 8'h00;
        @(negedge clock);
        #1;
        chk("reset_outputs", 64'(outs), 64'd0);
        reset = 1'b0;
        drive_byte(8'h00, 1'b0);

        foreach (tbl[k])
            run_frame(tbl[k].npre, tbl[k].sfd, tbl[k].len, tbl[k].npay, tbl[k].fcs_x,
                      tbl[k].abort_at, tbl[k].kind, 1'b0);

        // Reset asserted mid-payload clears everything at once.
        frame_no++;
        build_frame(16'd46, 46, 8'h00);
        repeat (7) drive_byte(8'h55, 1'b1);
        drive_byte(8'hD5, 1'b1);
        for (int i = 0; i < 24; i++) drive_byte(frm_q[i], 1'b1);
        chk("busy_mid_payload", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("reset_mid_payload", 64'(outs), 64'd0);
        @(negedge clock);
        #1;
        reset   = 1'b0;
        exp_cnt = 4'd0;
        drive_byte(8'h00, 1'b0);

        // Sixteen back-to-back good frames: counter walks 1..15 and wraps to 0.
        for (int k = 0; k < 16; k++)
            run_frame(7, 8'hD5, 16'd46, 46, 8'h00, -1, KOk, 1'b1);
        chk("counter_wrapped", 64'(valid_packet_counter), 64'd0);
        drive_byte(8'h00, 1'b0);

        // Random frames against the outcome model.
        for (int k = 0; k < 24; k++) begin
            int          npre;
            logic [7:0]  sfd;
            int          len;
            int          npay;
            logic [7:0]  fcs_x;
            int          abort_at;
            int          sel;
            npre  = ($urandom_range(9) == 0) ? 6 : 7;
            sfd   = ($urandom_range(9) == 0) ? 8'hD4 : 8'hD5;
            sel   = $urandom_range(9);
            if (sel < 7)       len = $urandom_range(90, MinPay);
            else if (sel == 7) len = $urandom_range(MinPay - 1, 0);
            else if (sel == 8) len = $urandom_range(1600, MaxPay + 1);
            else               len = MinPay;
            npay  = (len >= MinPay && len <= MaxPay) ? len : 0;
            fcs_x = ($urandom_range(2) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
            abort_at = -1;
            if ($urandom_range(4) == 0)
                abort_at = (npay > 0) ? $urandom_range(14 + npay + 3, 0) : $urandom_range(13, 0);
            run_frame(npre, sfd, 16'(len), npay, fcs_x, abort_at,
                      classify(npre, sfd, len, fcs_x, abort_at), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/payload_crc_sequencer.md
Name: payload_crc_sequencer

Overview:
Receive-side controller that sequences the payload CRC engine for an Ethernet-style byte stream. It tracks frame fields (preamble/SFD, dst, src, type_length, payload, FCS) and drives the CRC engine's init, enable and data inputs across dst..payload. It then compares the engine result against the received FCS, reports per-frame status and counts good frames. It sits between the byte input (data/control) and the payload CRC engine.

Parameters:
MIN_PAYLOAD, 46, minimum legal payload length in bytes
MAX_PAYLOAD, 1500, maximum legal payload length in bytes
CNT_W, 4, width of valid_packet_counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
data  input  8  received byte
control  input  1  byte valid / frame active; low mid-frame aborts the frame
crc_init  output  1  one-cycle pulse clearing the CRC engine
crc_enable  output  1  CRC engine consumes crc_data this cycle
crc_data  output  8  byte presented to the CRC engine
crc_value  input  32  CRC engine result, stable the cycle after the last crc_enable
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-cycle pulse: frame finished (good, bad or aborted)
frame_ok  output  1  valid with frame_done: length legal and CRC match
length_error  output  1  valid with frame_done: type_length out of range
crc_error  output  1  valid with frame_done: FCS mismatch
frame_abort  output  1  valid with frame_done: control dropped mid-frame
valid_packet_counter  output  CNT_W  count of frame_ok frames

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; counter 0; internal byte counters and fcs_reg cleared.
- A byte is accepted at a rising edge when control=1. All outputs are registered.
- States: IDLE, PREAMBLE, SFD, DST, SRC, TYPELEN, PAYLOAD, FCS, CHECK.
- IDLE: accepted 0x55 -> PREAMBLE, preamble count=1.
- PREAMBLE: 0x55 increments the count; at count 7 -> SFD. Any other byte -> IDLE.
- SFD: 0xD5 -> DST and pulse crc_init for the following cycle. Any other byte -> IDLE.
- No frame_done is issued for failures in IDLE, PREAMBLE or SFD, or when control is low in those states.
- DST: 6 bytes. SRC: 6 bytes. TYPELEN: 2 bytes, big-endian, latched into len[15:0].
- Length check on the 2nd TYPELEN byte:
  - len<MIN_PAYLOAD or len>MAX_PAYLOAD -> IDLE, frame_done=1 and length_error=1 next cycle, counter unchanged.
  - Otherwise -> PAYLOAD.
- PAYLOAD: exactly len bytes, then -> FCS.
- CRC feed: every byte accepted in DST, SRC, TYPELEN and PAYLOAD produces, one cycle later, crc_enable=1 with crc_data equal to that byte. crc_enable=0 otherwise. Preamble, SFD and FCS bytes are never fed.
- FCS: 4 bytes, little-endian into fcs_reg (first byte -> bits 7:0). The 4th byte -> CHECK.
- CHECK (one cycle, no byte consumed): compare fcs_reg with crc_value. Next edge -> IDLE with frame_done=1 and:
  - match: frame_ok=1, counter +1, wrapping 2^CNT_W-1 -> 0;
  - mismatch: crc_error=1.
- Latency: frame_done rises 2 edges after the edge accepting the last FCS byte.
- Abort: control=0 at a clock edge in DST..FCS -> IDLE, frame_done=1 and frame_abort=1 next cycle. No further crc_enable. Counter unchanged.
- control=1 during CHECK: the byte is ignored. A new preamble can be accepted from IDLE the cycle after CHECK.
- Status flags are mutually exclusive and are asserted only alongside frame_done; all flags are 0 otherwise.

Test Plan:
- Good frame, len=46, correct FCS -> crc_init once; 60 crc_enable pulses with data matching dst..payload in order; frame_done with frame_ok=1 two edges after the last FCS byte; counter 0->1.
- Same frame with FCS byte 0 XOR 0x01 -> frame_done with crc_error=1, frame_ok=0, counter unchanged.
- type_length=0x0600, then len=45 -> each gives frame_done with length_error=1 right after the TYPELEN bytes, no PAYLOAD crc_enable, counter unchanged.
- Preamble of six 0x55 then 0xD5, and seven 0x55 then 0xD4 -> no frame_done, busy returns 0, no crc_init.
- control low for one cycle at payload byte 10 -> frame_done with frame_abort=1; the following good frame gives frame_ok=1.
- 16 consecutive good back-to-back frames -> counter counts 1..15 then wraps to 0. Reset asserted mid-PAYLOAD -> all outputs 0 immediately, state IDLE, counter 0.
